// File: rtl/qadd_rr_arbiter.sv
// Round-robin front end for a shared sign-magnitude fixed-point adder.
// NREQ requesters compete for one adder; results return on a single registered, tagged channel.
module qadd_rr_arbiter #(
  parameter  int Q    = 15,
  parameter  int N    = 32,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_c,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_ovf
);

  // Sign-magnitude add: returns {ovf, sign, magnitude}. Zero magnitude is always positive.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sgn;
    logic         ovf;
    sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
    ovf = 1'b0;
    if (a[N-1] == b[N-1]) begin
      mag = sum[N-2:0];
      sgn = a[N-1];
      ovf = sum[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      mag = a[N-2:0] - b[N-2:0];
      sgn = a[N-1];
    end else begin
      mag = b[N-2:0] - a[N-2:0];
      sgn = b[N-1];
    end
    if (mag == '0) sgn = 1'b0;
    return {ovf, sgn, mag};
  endfunction

  logic [IDW-1:0] r_ptr;
  logic           r_vld_p1;
  logic [N-1:0]   r_c_p1;
  logic [IDW-1:0] r_id_p1;
  logic           r_ovf_p1;

  logic           w_found_p0;
  logic [IDW-1:0] w_gnt_p0;
  logic [IDW-1:0] w_idx;
  logic           w_can_accept;
  logic           w_xfer_p0;
  logic [N-1:0]   w_a_p0;
  logic [N-1:0]   w_b_p0;
  logic [N:0]     w_sum_p0;
  logic [NREQ-1:0] w_ready;

  // Stage p0: grant search starts just after the last granted index and wraps.
  always_comb begin
    w_found_p0 = 1'b0;
    w_gnt_p0   = '0;
    w_idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found_p0 && req_valid[w_idx]) begin
        w_found_p0 = 1'b1;
        w_gnt_p0   = w_idx;
      end
    end
  end

  assign w_can_accept = !r_vld_p1 || rsp_ready;
  assign w_xfer_p0    = !rst && w_found_p0 && w_can_accept;

  always_comb begin
    w_ready = '0;
    if (w_xfer_p0) w_ready[w_gnt_p0] = 1'b1;
  end

  assign req_ready = w_ready;
  assign w_a_p0    = req_a[w_gnt_p0*N +: N];
  assign w_b_p0    = req_b[w_gnt_p0*N +: N];
  assign w_sum_p0  = sm_add(w_a_p0, w_b_p0);

  // Stage p1: response slot; holds its data when drained without a new transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_c_p1   <= '0;
      r_id_p1  <= '0;
      r_ovf_p1 <= 1'b0;
      r_ptr    <= IDW'(NREQ - 1);
    end else if (w_xfer_p0) begin
      r_vld_p1 <= 1'b1;
      r_c_p1   <= w_sum_p0[N-1:0];
      r_id_p1  <= w_gnt_p0;
      r_ovf_p1 <= w_sum_p0[N];
      r_ptr    <= w_gnt_p0;
    end else if (rsp_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_c     = r_c_p1;
  assign rsp_id    = r_id_p1;
  assign rsp_ovf   = r_ovf_p1;

endmodule

// File: doc/qadd_rr_arbiter.md
Name: qadd_rr_arbiter

Overview:
- Shares one sign-magnitude fixed-point adder (Q fractional bits, N-bit word, MSB = sign) among NREQ requesters.
- Each requester submits an operand pair over a valid/ready handshake; a round-robin arbiter grants one per cycle.
- The sum returns on a single registered response channel, tagged with the requester index and an overflow flag.
- Sits between the fixed-point compute clients and the shared adder datapath.

Parameters:
- Q, 15, fractional bits; format tag only, no effect on arithmetic.
- N, 32, word width (1 sign bit + N-1 magnitude bits).
- NREQ, 4, number of requesters (≥2); IDW = clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*N  operand A, requester i at bits [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_c  out  N  sign-magnitude sum.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_ovf  out  1  magnitude overflow on a same-sign add.

Behaviour:
- Reset (synchronous, active-high): rsp_valid=0, rsp_c=0, rsp_id=0, rsp_ovf=0, rr pointer=NREQ-1 (requester 0 has first priority). req_ready=0 while rst=1.
- can_accept = !rsp_valid | rsp_ready. The output slot is empty, or it drains in the same cycle.
- Grant is combinational from req_valid and the pointer: the first valid index searching from ptr+1 upward, modulo NREQ.
- req_ready[g] = can_accept & req_valid[g]; all other bits are 0. req_ready never depends on a requester's own valid except through the grant.
- Transfer occurs when req_valid[g] & req_ready[g]. On the next edge:
  - rsp_c, rsp_id=g and rsp_ovf are loaded.
  - rsp_valid is set to 1.
  - ptr becomes g.
- ptr changes only on a transfer.
- Latency is 1 cycle from transfer to rsp_valid. Throughput is 1 result/cycle while rsp_ready=1.
- Drain without a new transfer: rsp_valid goes to 0 and rsp_c/rsp_id/rsp_ovf hold their values.
- While rsp_valid=1 and rsp_ready=0, all response outputs stay stable and all req_ready bits are 0.
- Requester operands need only be stable in the transfer cycle.
- Arithmetic (combinational on the granted operands; ma/mb = low N-1 bits, sa/sb = sign bits):
  - Same sign: magnitude = (ma+mb) mod 2^(N-1), sign = sa. ovf = carry out of bit N-2.
  - Different sign: magnitude = |ma-mb|. Sign is that of the operand with the larger magnitude; for ma==mb the sign is 0. ovf=0.
  - A result magnitude of 0 always has sign 0 (no negative zero), including after a wrapped overflow.
- Boundary cases:
  - A requester that drops valid before being granted is simply skipped.
  - A single active requester is granted every cycle.
  - Pointer wrap from NREQ-1 to 0 is required.
  - Reset asserted mid-transfer or with rsp_valid=1 discards the in-flight result; there is no response after reset deasserts.
  - Simultaneous drain and new transfer is legal and loses no result.

Test Plan:
- Mixed signs: req0 a=0x00018000 (3.0), b=0x80008000 (-1.0), rsp_ready=1 → next cycle rsp_valid=1, rsp_c=0x00010000, rsp_id=0, rsp_ovf=0.
- Negative zero and negative sum:
  - req2 a=0x00008000, b=0x80008000 → rsp_c=0x00000000.
  - Then a=0x80000001, b=0x80000002 → rsp_c=0x80000003, rsp_id=2.
- Overflow: a=0x7FFFFFFF, b=0x00000001 → rsp_c=0x00000000, rsp_ovf=1. Also a=0xFFFFFFFF, b=0x80000001 → rsp_c=0x00000000, rsp_ovf=1.
- Round-robin fairness: all four req_valid held high from reset, rsp_ready=1 → req_ready one-hot sequence 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later; no cycle without a grant.
- Backpressure: after a result is valid, hold rsp_ready=0 for 5 cycles with req1 and req3 valid → req_ready=0 and rsp_* stable throughout. On release, rsp_ready=1 and req_ready for the next RR index rise in the same cycle, with no lost or duplicated result.
- Reset mid-operation: assert rst in the cycle after a transfer while rsp_valid=1 → next edge rsp_valid=0, rsp_c=0, rsp_id=0, ptr=NREQ-1. The first grant after reset goes to requester 0 when all are valid.
